fa_step4: RTL and testbench

FA_STEP4 -- requirements
Module: fa_step4

---
 rtl/fa_step4_pkg.sv | 20 ++
 rtl/fa_step4_lzc25.sv | 20 ++
 rtl/fa_step4.sv | 181 ++++++++++++++++++
 tb/tb_fa_step4.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fa_step4_pkg.sv
// Shared constants and result type for the single-precision final-adder
// step: sum formation, normalisation, rounding and IEEE-754 packing.
package fa_step4_pkg;

    localparam int MANT_W  = 25;   // sum width, including the overflow bit
    localparam int EXP_W   = 8;
    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;
    localparam int FRAC_W  = 23;
    localparam int LZC_W   = 5;
    localparam int FP_W    = 1 + EXP_W + FRAC_W;

    // Packed stage-B result: the IEEE word plus its two status flags.
    typedef struct packed {
        logic [FP_W-1:0] word;
        logic            zero;
        logic            inf;
    } fp_out_t;

endpackage

// File: rtl/fa_step4_lzc25.sv
// Leading-zero counter over the 24-bit non-overflow part of the sum.
// An all-zero input reports 24; the caller treats a zero sum separately.
module lzc25
    import fa_step4_pkg::*;
(
    input  logic [MANT_W-2:0] data_i,
    output logic [LZC_W-1:0]  cnt_o
);

    // Scan upwards so the highest set bit is the last to set the count.
    always_comb begin
        cnt_o = LZC_W'(MANT_W - 1);
        for (int i = 0; i < MANT_W - 1; i++) begin
            if (data_i[i]) begin
                cnt_o = LZC_W'(MANT_W - 2 - i);
            end
        end
    end

endmodule

// File: rtl/fa_step4.sv
// Final adder step: forms the sum from propagate/group-generate vectors,
// counts leading zeros (stage A), then normalises, rounds and packs an
// IEEE-754 single result (stage B). Two-cycle latency, one result per cycle.
module fa_step4
    import fa_step4_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              in_valid,
    input  logic              in_sign,
    input  logic              in_yn,
    input  logic [EXP_W-1:0]  in_ex,
    input  logic [MANT_W-1:0] in_P0,
    input  logic [MANT_W-1:0] in_GG,
    output logic              out_valid,
    output logic [FP_W-1:0]   out_result,
    output logic              out_zero,
    output logic              out_inf
);

    localparam logic [EXP_W-1:0]        EXP_ALL1  = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W + 2)'(EXP_MAX);
    localparam fp_out_t ZERO_RES = '{word: '0, zero: 1'b1, inf: 1'b0};

    // Round to nearest even on the dropped bit s[0]; bit MANT_W-1 of the
    // return value is the carry out of the 24-bit mantissa.
    function automatic logic [MANT_W-1:0] round_rne(input logic [MANT_W-1:0] s);
        logic inc;
        inc = s[0] & s[1];
        return {1'b0, s[MANT_W-1:1]} + MANT_W'(inc);
    endfunction

    // Signed infinity with the overflow flag.
    function automatic fp_out_t sat_inf(input logic sign);
        fp_out_t r;
        r.word = {sign, EXP_ALL1, {FRAC_W{1'b0}}};
        r.zero = 1'b0;
        r.inf  = 1'b1;
        return r;
    endfunction

    // Ordinary finite packing; the hidden bit is not stored.
    function automatic fp_out_t pack_fin(input logic sign, input logic [EXP_W-1:0] e,
                                         input logic [FRAC_W-1:0] frac);
        fp_out_t r;
        r.word = {sign, e, frac};
        r.zero = 1'b0;
        r.inf  = 1'b0;
        return r;
    endfunction

    // Saturate an exponent that reached the all-ones code to infinity.
    function automatic fp_out_t sat_exp(input logic sign, input logic signed [EXP_W+1:0] e,
                                        input logic [FRAC_W-1:0] frac);
        if (e >= EXP_MAX_S) begin
            return sat_inf(sign);
        end
        return pack_fin(sign, e[EXP_W-1:0], frac);
    endfunction

    // ---------------- stage p0: sum formation and leading-zero count
    logic [MANT_W-1:0] sum_p0;
    logic [LZC_W-1:0]  lzc_p0;
    logic              gg_top_unused;

    // The top group-generate bit is the carry out of the whole sum and is not needed.
    assign gg_top_unused = in_GG[MANT_W-1];

    // Bit i of the sum is the propagate bit XOR the carry into bit i; under
    // effective subtraction the result is non-negative, so the overflow bit is dropped.
    always_comb begin
        sum_p0    = '0;
        sum_p0[0] = in_P0[0] ^ in_yn;
        for (int i = 1; i < MANT_W; i++) begin
            sum_p0[i] = in_P0[i] ^ in_GG[i-1];
        end
        if (in_yn) begin
            sum_p0[MANT_W-1] = 1'b0;
        end
    end

    lzc25 u_lzc (
        .data_i (sum_p0[MANT_W-2:0]),
        .cnt_o  (lzc_p0)
    );

    // ---------------- stage p1: registered sign, exponent, sum, lzc, overflow bit
    logic              vld_p1_q;
    logic              sign_p1_q;
    logic              ovf_p1_q;
    logic [EXP_W-1:0]  ex_p1_q;
    logic [MANT_W-2:0] sum_p1_q;
    logic [LZC_W-1:0]  lzc_p1_q;

    // Stage A register: valid always advances, data loads only on a valid input.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_p1_q  <= 1'b0;
            sign_p1_q <= 1'b0;
            ovf_p1_q  <= 1'b0;
            ex_p1_q   <= '0;
            sum_p1_q  <= '0;
            lzc_p1_q  <= '0;
        end else begin
            vld_p1_q <= in_valid;
            if (in_valid) begin
                sign_p1_q <= in_sign;
                ovf_p1_q  <= sum_p0[MANT_W-1];
                ex_p1_q   <= in_ex;
                sum_p1_q  <= sum_p0[MANT_W-2:0];
                lzc_p1_q  <= lzc_p0;
            end
        end
    end

    // ---------------- stage p2: normalise, round, pack
    fp_out_t                  res_p2_d;
    fp_out_t                  res_p2_q;
    logic                     vld_p2_q;
    logic [MANT_W-1:0]        rnd;
    logic [FRAC_W-1:0]        frac;
    logic signed [EXP_W+1:0]  exp_ovf;
    logic [EXP_W-1:0]         exp_norm;
    logic [MANT_W-2:0]        norm;
    logic                     hidden_unused;

    // Result selection: special input exponent, overflow path, zero,
    // underflow flush, then the left-normalise path.
    always_comb begin
        res_p2_d      = '0;
        rnd           = '0;
        frac          = '0;
        exp_ovf       = '0;
        exp_norm      = '0;
        norm          = '0;
        hidden_unused = 1'b0;
        if (ex_p1_q == EXP_ALL1) begin
            res_p2_d = sat_inf(sign_p1_q);
        end else if (ovf_p1_q) begin
            rnd = round_rne({1'b1, sum_p1_q});
            hidden_unused = rnd[MANT_W-2];
            if (rnd[MANT_W-1]) begin
                // Rounding carried to 2.0: mantissa becomes 1.0, one more exponent step.
                frac    = '0;
                exp_ovf = $signed({2'b00, ex_p1_q}) + 10'sd2;
            end else begin
                frac    = rnd[FRAC_W-1:0];
                exp_ovf = $signed({2'b00, ex_p1_q}) + 10'sd1;
            end
            res_p2_d = sat_exp(sign_p1_q, exp_ovf, frac);
        end else if (sum_p1_q == '0) begin
            res_p2_d = ZERO_RES;
        end else if (ex_p1_q <= {3'b000, lzc_p1_q}) begin
            res_p2_d = ZERO_RES;
        end else begin
            norm          = sum_p1_q << lzc_p1_q;
            exp_norm      = ex_p1_q - {3'b000, lzc_p1_q};
            hidden_unused = norm[MANT_W-2];
            res_p2_d      = pack_fin(sign_p1_q, exp_norm, norm[FRAC_W-1:0]);
        end
    end

    // Stage B register: valid always advances, result loads only behind a valid stage A.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                res_p2_q <= res_p2_d;
            end
        end
    end

    assign out_valid  = vld_p2_q;
    assign out_result = res_p2_q.word;
    assign out_zero   = res_p2_q.zero;
    assign out_inf    = res_p2_q.inf;

endmodule

// File: tb/tb_fa_step4.sv
// Directed bench for fa_step4: reset state, each result path, rounding and
// exponent boundaries, and a streaming sequence interrupted by reset.
module tb_fa_step4;

    logic        CLK;
    logic        RESETn;
    logic        in_valid;
    logic        in_sign;
    logic        in_yn;
    logic [7:0]  in_ex;
    logic [24:0] in_P0;
    logic [24:0] in_GG;
    logic        out_valid;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_inf;

    int n_vec;
    int n_miss;

    fa_step4 dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .in_valid   (in_valid),
        .in_sign    (in_sign),
        .in_yn      (in_yn),
        .in_ex      (in_ex),
        .in_P0      (in_P0),
        .in_GG      (in_GG),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_inf    (out_inf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic yn, input logic [7:0] ex,
                         input logic [24:0] p0, input logic [24:0] gg);
        in_valid = 1'b1;
        in_sign  = s;
        in_yn    = yn;
        in_ex    = ex;
        in_P0    = p0;
        in_GG    = gg;
    endtask

    // One isolated transaction: no output one cycle after capture, result after two.
    task automatic run_vec(input string tag, input logic s, input logic yn,
                           input logic [7:0] ex, input logic [24:0] p0, input logic [24:0] gg,
                           input logic [31:0] want, input logic wz, input logic wi);
        drive(s, yn, ex, p0, gg);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_vld"},  32'(out_valid), 32'd1);
        chk({tag, "_res"},  out_result, want);
        chk({tag, "_zero"}, 32'(out_zero), 32'(wz));
        chk({tag, "_inf"},  32'(out_inf),  32'(wi));
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        RESETn   = 1'b0;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_yn    = 1'b0;
        in_ex    = '0;
        in_P0    = '0;
        in_GG    = '0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_vld",  32'(out_valid), 32'd0);
        chk("rst_res",  out_result,     32'd0);
        chk("rst_zero", 32'(out_zero),  32'd0);
        chk("rst_inf",  32'(out_inf),   32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;

        //       tag        s     yn    ex      P0            GG            result        z     i
        run_vec("ovf",      1'b0, 1'b0, 8'd127, 25'h1000000, 25'h0000000, 32'h40000000, 1'b0, 1'b0);
        run_vec("lnorm",    1'b0, 1'b0, 8'd127, 25'h0000100, 25'h0000000, 32'h38000000, 1'b0, 1'b0);
        run_vec("rcarry",   1'b0, 1'b0, 8'd127, 25'h1FFFFFF, 25'h0000000, 32'h40800000, 1'b0, 1'b0);
        run_vec("cancel",   1'b1, 1'b1, 8'd127, 25'h0000001, 25'h0000000, 32'h00000000, 1'b1, 1'b0);
        run_vec("expovf",   1'b0, 1'b0, 8'd254, 25'h1000000, 25'h0000000, 32'h7F800000, 1'b0, 1'b1);
        run_vec("exp255",   1'b1, 1'b0, 8'd255, 25'h0800000, 25'h0000000, 32'hFF800000, 1'b0, 1'b1);
        run_vec("uflow",    1'b0, 1'b0, 8'd15,  25'h0000100, 25'h0000000, 32'h00000000, 1'b1, 1'b0);
        run_vec("minnorm",  1'b0, 1'b0, 8'd16,  25'h0000100, 25'h0000000, 32'h00800000, 1'b0, 1'b0);
        run_vec("tie_even", 1'b0, 1'b0, 8'd127, 25'h1000001, 25'h0000000, 32'h40000000, 1'b0, 1'b0);
        run_vec("tie_odd",  1'b0, 1'b0, 8'd127, 25'h1000003, 25'h0000000, 32'h40000002, 1'b0, 1'b0);
        run_vec("gg_carry", 1'b0, 1'b0, 8'd127, 25'h0000000, 25'h0000001, 32'h34800000, 1'b0, 1'b0);
        run_vec("cin",      1'b0, 1'b1, 8'd127, 25'h0000000, 25'h0000000, 32'h34000000, 1'b0, 1'b0);
        run_vec("yn_drop",  1'b0, 1'b1, 8'd127, 25'h1000000, 25'h0000000, 32'h34000000, 1'b0, 1'b0);
        run_vec("neg_ovf",  1'b1, 1'b0, 8'd127, 25'h1000000, 25'h0000000, 32'hC0000000, 1'b0, 1'b0);
        run_vec("lzc0",     1'b0, 1'b0, 8'd127, 25'h0800001, 25'h0000000, 32'h3F800001, 1'b0, 1'b0);

        // Streaming: four back-to-back inputs, reset pulsed while the third is in flight.
        drive(1'b0, 1'b0, 8'd127, 25'h1000000, 25'h0);           // v1
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, 8'd127, 25'h0000100, 25'h0);           // v2
        @(posedge CLK); #1;
        chk("s_v1_vld", 32'(out_valid), 32'd1);
        chk("s_v1_res", out_result, 32'h40000000);
        drive(1'b0, 1'b0, 8'd127, 25'h1FFFFFF, 25'h0);           // v3, discarded
        @(posedge CLK); #1;
        chk("s_v2_vld", 32'(out_valid), 32'd1);
        chk("s_v2_res", out_result, 32'h38000000);
        drive(1'b0, 1'b0, 8'd130, 25'h1000000, 25'h0);           // v4
        #1;
        RESETn = 1'b0;
        #1;
        chk("s_rst_vld",  32'(out_valid), 32'd0);
        chk("s_rst_res",  out_result,     32'd0);
        chk("s_rst_zero", 32'(out_zero),  32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("s_v3_gone", 32'(out_valid), 32'd0);
        @(posedge CLK); #1;
        chk("s_v4_vld", 32'(out_valid), 32'd1);
        chk("s_v4_res", out_result, 32'h41800000);
        @(posedge CLK); #1;
        chk("s_idle", 32'(out_valid), 32'd0);
        chk("s_hold", out_result, 32'h41800000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
